// File: rtl/cbi980_pkg.sv
// Shared constants and types for the CBI980 I2S codec engine.
package cbi980_pkg;

  localparam int SAMPLE_BITS = 24;
  localparam int SLOT_BITS   = 32;
  localparam int FRAME_BITS  = 64;
  localparam int RATE_W      = 3;
  localparam int BITCNT_W    = $clog2(FRAME_BITS);
  localparam int SLOT_W      = $clog2(SLOT_BITS);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    SETTLE   = 2'd1,
    RUN      = 2'd2
  } init_state_t;

endpackage

// File: rtl/i2s_clkgen.sv
// MCLK/SCLK prescaler with frame-aligned rate latch; emits one-cycle SCLK edge strobes.
module i2s_clkgen
  import cbi980_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              frame_wrap,
  input  logic [RATE_W-1:0] mclk_rate,
  input  logic [RATE_W-1:0] sclk_rate,
  output logic              mclk,
  output logic              sclk,
  output logic              sclk_rise,
  output logic              sclk_fall
);

  localparam int MCNT_W = (1 << RATE_W) - 1;
  localparam int SCNT_W = 2 * MCNT_W + 1;

  logic [RATE_W-1:0] mrate, srate;
  logic [MCNT_W-1:0] mcnt, mlim;
  logic [SCNT_W-1:0] scnt, slim;
  logic [4:0]        sexp;
  logic              stick;

  // SCLK half-period in clk cycles = 2^(mclk_rate + sclk_rate + 1)
  always_comb begin
    mlim = MCNT_W'((32'd1 << mrate) - 32'd1);
    sexp = 5'(mrate) + 5'(srate) + 5'd1;
    slim = SCNT_W'((32'd1 << sexp) - 32'd1);
  end

  assign stick     = run && (scnt >= slim);
  assign sclk_rise = stick && !sclk;
  assign sclk_fall = stick && sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      mrate <= mclk_rate;
      srate <= sclk_rate;
      mcnt  <= '0;
      mclk  <= 1'b0;
      scnt  <= '0;
      sclk  <= 1'b0;
    end else begin
      if (frame_wrap) begin
        mrate <= mclk_rate;
        srate <= sclk_rate;
      end
      // >= so a rate drop at the wrap cannot strand the counter above its limit
      if (mcnt >= mlim) begin
        mcnt <= '0;
        mclk <= ~mclk;
      end else begin
        mcnt <= mcnt + 1'b1;
      end
      if (!run) begin
        scnt <= '0;
        sclk <= 1'b0;
      end else if (stick) begin
        scnt <= '0;
        sclk <= ~sclk;
      end else begin
        scnt <= scnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_codec_engine.sv
// I2S engine: codec power-up sequencing, 64-bit frame serialiser/deserialiser, FIFO strobes.
module i2s_codec_engine
  import cbi980_pkg::*;
#(
  parameter int RSTN_CYC = 256,
  parameter int INIT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RATE_W-1:0]      mclk_rate,
  input  logic [RATE_W-1:0]      sclk_rate,
  output logic                   init_done,
  output logic                   codec_rstn,
  output logic                   codec_mclk,
  output logic                   codec_lrclk,
  output logic                   codec_sclk,
  output logic                   codec_sdin,
  input  logic                   codec_sdout,
  output logic [1:0]             aud_din_ack,
  input  logic [SAMPLE_BITS-1:0] aud_din0,
  input  logic [SAMPLE_BITS-1:0] aud_din1,
  output logic [1:0]             aud_dout_vld,
  output logic [SAMPLE_BITS-1:0] aud_dout
);

  localparam int CNT_W = $clog2((RSTN_CYC > INIT_CYC) ? RSTN_CYC : INIT_CYC) + 1;

  init_state_t            state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   run, sclk_rise, sclk_fall, frame_wrap;
  logic [BITCNT_W-1:0]    bitcnt, bitcnt_nxt;
  logic [SLOT_W-1:0]      pos, pos_nxt;
  logic                   tx_slot_bit, rx_slot_bit;
  logic [SAMPLE_BITS-1:0] tx_sh, rx_sh;
  logic                   rx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_HOLD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      RST_HOLD: if (cnt == CNT_W'(RSTN_CYC - 1)) begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
      SETTLE: if (cnt == CNT_W'(INIT_CYC - 1)) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
      default: cnt_nxt = '0;
    endcase
  end

  assign run        = (state == RUN);
  assign init_done  = run;
  assign codec_rstn = (state != RST_HOLD);

  i2s_clkgen u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .frame_wrap (frame_wrap),
    .mclk_rate  (mclk_rate),
    .sclk_rate  (sclk_rate),
    .mclk       (codec_mclk),
    .sclk       (codec_sclk),
    .sclk_rise  (sclk_rise),
    .sclk_fall  (sclk_fall)
  );

  assign bitcnt_nxt  = bitcnt + BITCNT_W'(1);
  assign pos         = bitcnt[SLOT_W-1:0];
  assign pos_nxt     = bitcnt_nxt[SLOT_W-1:0];
  assign frame_wrap  = sclk_fall && (bitcnt == '1);
  assign tx_slot_bit = (pos_nxt != '0) && (pos_nxt <= SLOT_W'(SAMPLE_BITS));
  assign rx_slot_bit = (pos != '0) && (pos <= SLOT_W'(SAMPLE_BITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt       <= '1;
      codec_lrclk  <= 1'b0;
      codec_sdin   <= 1'b0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      rx_done      <= 1'b0;
      aud_dout     <= '0;
      aud_din_ack  <= '0;
      aud_dout_vld <= '0;
    end else begin
      aud_din_ack  <= '0;
      aud_dout_vld <= '0;
      rx_done      <= 1'b0;
      if (sclk_fall) begin
        bitcnt      <= bitcnt_nxt;
        codec_lrclk <= bitcnt_nxt[BITCNT_W-1];
        if (pos_nxt == '0) aud_din_ack[bitcnt_nxt[BITCNT_W-1]] <= 1'b1;
        if (tx_slot_bit) begin
          codec_sdin <= tx_sh[SAMPLE_BITS-1];
          tx_sh      <= {tx_sh[SAMPLE_BITS-2:0], 1'b0};
        end else begin
          codec_sdin <= 1'b0;
        end
      end
      // ack is high for the cycle after the p=0 fall; sample lands on the edge ending it
      if (aud_din_ack[0])      tx_sh <= aud_din0;
      else if (aud_din_ack[1]) tx_sh <= aud_din1;
      if (sclk_rise && rx_slot_bit) begin
        rx_sh   <= {rx_sh[SAMPLE_BITS-2:0], codec_sdout};
        rx_done <= (pos == SLOT_W'(SAMPLE_BITS));
      end
      if (rx_done) begin
        aud_dout                           <= rx_sh;
        aud_dout_vld[bitcnt[BITCNT_W-1]] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_codec_engine.sv
// Directed bench for i2s_codec_engine: init sequence, frame timing, TX/RX loopback, rate change, reset.
module tb_i2s_codec_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mclk_rate = 3'd0;
  logic [2:0]  sclk_rate = 3'd2;
  logic        init_done, codec_rstn, codec_mclk, codec_lrclk, codec_sclk, codec_sdin;
  logic        codec_sdout;
  logic [1:0]  aud_din_ack, aud_dout_vld;
  logic [23:0] aud_din0 = 24'hA5A5A5;
  logic [23:0] aud_din1 = 24'h123456;
  logic [23:0] aud_dout;

  int errors = 0;
  int checks = 0;

  i2s_codec_engine #(.RSTN_CYC(8), .INIT_CYC(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .mclk_rate    (mclk_rate),
    .sclk_rate    (sclk_rate),
    .init_done    (init_done),
    .codec_rstn   (codec_rstn),
    .codec_mclk   (codec_mclk),
    .codec_lrclk  (codec_lrclk),
    .codec_sclk   (codec_sclk),
    .codec_sdin   (codec_sdin),
    .codec_sdout  (codec_sdout),
    .aud_din_ack  (aud_din_ack),
    .aud_din0     (aud_din0),
    .aud_din1     (aud_din1),
    .aud_dout_vld (aud_dout_vld),
    .aud_dout     (aud_dout)
  );

  assign codec_sdout = codec_sdin;
  always #5 clk = ~clk;

  // per-frame observations, filled by capture_frame
  int   f_falls, f_cyc, f_lr_hi, f_lr_bad, f_ack0, f_ack1, f_ack_bad;
  int   f_vld0, f_vld1, f_vld_bad, f_per_min, f_per_max, f_mh_min, f_mh_max;
  logic [23:0] f_dout0, f_dout1;
  logic f_sdin [64];

  // Entry: negedge right after the SCLK fall that starts a frame (p=0).
  // Exit: negedge right after the fall that starts the following frame.
  task automatic capture_frame(input int chg_p, input logic [2:0] chg_rate);
    int p, lf, lt, d;
    logic ps, pm, fell;
    p = 0; lf = 0; lt = -1;
    f_falls = 0; f_cyc = 0; f_lr_hi = 0; f_lr_bad = 0; f_ack0 = 0; f_ack1 = 0; f_ack_bad = 0;
    f_vld0 = 0; f_vld1 = 0; f_vld_bad = 0; f_dout0 = 'x; f_dout1 = 'x;
    f_per_min = 1000000; f_per_max = 0; f_mh_min = 1000000; f_mh_max = 0;
    ps = codec_sclk; pm = codec_mclk;
    for (int n = 0; n < 5000; n++) begin
      fell = 1'b0;
      f_cyc = n;
      if (n > 0) begin
        @(negedge clk);
        if (codec_mclk !== pm) begin
          if (lt >= 0) begin
            d = n - lt;
            if (d < f_mh_min) f_mh_min = d;
            if (d > f_mh_max) f_mh_max = d;
          end
          lt = n;
          pm = codec_mclk;
        end
        if (ps && !codec_sclk) begin
          fell = 1'b1;
          f_falls++;
          d = n - lf;
          if (d < f_per_min) f_per_min = d;
          if (d > f_per_max) f_per_max = d;
          lf = n;
          p = (p + 1) % 64;
        end
        ps = codec_sclk;
        if (f_falls == 64) break;
      end else begin
        fell = 1'b1;
      end
      if (fell) f_sdin[p] = codec_sdin;
      if (codec_lrclk !== (p >= 32)) f_lr_bad++;
      if (codec_lrclk === 1'b1) f_lr_hi++;
      if (aud_din_ack === 2'b01 && fell && p == 0) f_ack0++;
      else if (aud_din_ack === 2'b10 && fell && p == 32) f_ack1++;
      else if (aud_din_ack !== 2'b00) f_ack_bad++;
      if (aud_dout_vld === 2'b01 && p == 24) begin f_vld0++; f_dout0 = aud_dout; end
      else if (aud_dout_vld === 2'b10 && p == 56) begin f_vld1++; f_dout1 = aud_dout; end
      else if (aud_dout_vld !== 2'b00) f_vld_bad++;
      if (fell && p == chg_p) mclk_rate = chg_rate;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({codec_rstn, codec_mclk, codec_sclk, codec_lrclk, codec_sdin, init_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pins: got %b want 000000",
               {codec_rstn, codec_mclk, codec_sclk, codec_lrclk, codec_sdin, init_done});
    end
    checks++;
    if ({aud_din_ack, aud_dout_vld} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000", {aud_din_ack, aud_dout_vld});
    end
    checks++;
    if (aud_dout !== 24'h0) begin
      errors++; $display("FAIL reset_dout: got %h want 000000", aud_dout);
    end
  endtask

  task automatic test_init;
    int mbad, sbad;
    logic [31:0] kk;
    mbad = 0; sbad = 0;
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      kk = k;
      if (codec_mclk !== kk[0]) mbad++;
      if (codec_sclk !== 1'b0) sbad++;
      if (k == 7) begin
        checks++;
        if (codec_rstn !== 1'b0) begin errors++; $display("FAIL rstn_hold: got %b want 0 at cycle 7", codec_rstn); end
      end
      if (k == 8) begin
        checks++;
        if (codec_rstn !== 1'b1) begin errors++; $display("FAIL rstn_rise: got %b want 1 at cycle 8", codec_rstn); end
      end
      if (k == 23) begin
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL settle: got init_done=%b want 0 at cycle 23", init_done); end
      end
      if (k == 24) begin
        checks++;
        if (init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b want 1 at cycle 24", init_done); end
      end
    end
    checks++;
    if (mbad != 0) begin errors++; $display("FAIL mclk_during_init: got %0d bad cycles want 0", mbad); end
    checks++;
    if (sbad != 0) begin errors++; $display("FAIL sclk_before_run: got %0d active cycles want 0", sbad); end
  endtask

  task automatic test_first_frame;
    int rise_i, ack_i;
    logic [1:0] ack_v;
    rise_i = -1; ack_i = -1; ack_v = 2'b00;
    for (int i = 1; i <= 40 && ack_i < 0; i++) begin
      @(negedge clk);
      if (rise_i < 0 && codec_sclk === 1'b1) rise_i = i;
      if (aud_din_ack !== 2'b00) begin ack_i = i; ack_v = aud_din_ack; end
    end
    checks++;
    if (rise_i != 8) begin errors++; $display("FAIL first_sclk_rise: got %0d want 8 cycles", rise_i); end
    checks++;
    if (ack_i != 16) begin errors++; $display("FAIL first_ack_time: got %0d want 16 cycles", ack_i); end
    checks++;
    if (ack_v !== 2'b01 || codec_sclk !== 1'b0) begin
      errors++; $display("FAIL first_ack_chan: got ack=%b sclk=%b want ack=01 sclk=0", ack_v, codec_sclk);
    end
  endtask

  task automatic check_sdin(input string tag);
    int bad, q;
    logic [23:0] d;
    logic e;
    bad = 0;
    for (int p = 0; p < 64; p++) begin
      d = (p < 32) ? aud_din0 : aud_din1;
      q = p % 32;
      e = (q >= 1 && q <= 24) ? d[24 - q] : 1'b0;
      if (f_sdin[p] !== e) bad++;
    end
    checks++;
    if (bad != 0 || f_falls != 64) begin
      errors++; $display("FAIL %s_sdin: got %0d bad bits, %0d falls want 0 bad, 64 falls", tag, bad, f_falls);
    end
  endtask

  task automatic test_tx;
    capture_frame(-1, 3'd0);
    check_sdin("tx");
    checks++;
    if (f_ack0 != 1 || f_ack1 != 1) begin
      errors++; $display("FAIL tx_acks: got ack0=%0d ack1=%0d want 1 each", f_ack0, f_ack1);
    end
    checks++;
    if (f_ack_bad != 0) begin errors++; $display("FAIL tx_stray_ack: got %0d want 0", f_ack_bad); end
  endtask

  task automatic test_rates;
    capture_frame(-1, 3'd0);
    checks++;
    if (f_mh_min != 1 || f_mh_max != 1) begin
      errors++; $display("FAIL mclk_half: got %0d..%0d want 1..1 clk", f_mh_min, f_mh_max);
    end
    checks++;
    if (f_per_min != 16 || f_per_max != 16) begin
      errors++; $display("FAIL sclk_period: got %0d..%0d want 16..16 clk", f_per_min, f_per_max);
    end
    checks++;
    if (f_cyc != 1024) begin errors++; $display("FAIL lrclk_period: got %0d want 1024 clk", f_cyc); end
    checks++;
    if (f_lr_hi != 512 || f_lr_bad != 0) begin
      errors++; $display("FAIL lrclk_duty: got high=%0d bad=%0d want high=512 bad=0", f_lr_hi, f_lr_bad);
    end
  endtask

  task automatic test_loopback;
    capture_frame(-1, 3'd0);
    checks++;
    if (f_vld0 != 1 || f_dout0 !== 24'hA5A5A5) begin
      errors++; $display("FAIL loop_ch0: got vld=%0d dout=%h want vld=1 dout=a5a5a5", f_vld0, f_dout0);
    end
    checks++;
    if (f_vld1 != 1 || f_dout1 !== 24'h123456) begin
      errors++; $display("FAIL loop_ch1: got vld=%0d dout=%h want vld=1 dout=123456", f_vld1, f_dout1);
    end
    checks++;
    if (f_vld_bad != 0) begin errors++; $display("FAIL loop_stray_vld: got %0d want 0", f_vld_bad); end
  endtask

  task automatic test_rate_change;
    capture_frame(20, 3'd1);
    checks++;
    if (f_per_min != 16 || f_per_max != 16 || f_mh_max != 1) begin
      errors++; $display("FAIL rate_hold: got sclk %0d..%0d mclk_half max %0d want 16..16, 1",
                         f_per_min, f_per_max, f_mh_max);
    end
    check_sdin("rate_hold");
    capture_frame(-1, 3'd0);
    checks++;
    if (f_per_min != 32 || f_per_max != 32) begin
      errors++; $display("FAIL rate_new_sclk: got %0d..%0d want 32..32 clk", f_per_min, f_per_max);
    end
    checks++;
    if (f_mh_min != 2 || f_mh_max != 2) begin
      errors++; $display("FAIL rate_new_mclk: got %0d..%0d want 2..2 clk", f_mh_min, f_mh_max);
    end
    checks++;
    if (f_cyc != 2048 || f_lr_bad != 0) begin
      errors++; $display("FAIL rate_new_frame: got %0d clk lr_bad=%0d want 2048 clk lr_bad=0", f_cyc, f_lr_bad);
    end
    check_sdin("rate_new");
    checks++;
    if (f_vld0 != 1 || f_vld1 != 1 || f_dout1 !== 24'h123456) begin
      errors++; $display("FAIL rate_new_rx: got vld0=%0d vld1=%0d dout1=%h want 1 1 123456", f_vld0, f_vld1, f_dout1);
    end
  endtask

  task automatic test_reset_midslot;
    int wait_n, k_done, ack_i;
    logic ps, fell_at_ack;
    logic [1:0] ack_v;
    wait_n = 0;
    while (codec_lrclk !== 1'b1 && wait_n < 3000) begin @(negedge clk); wait_n++; end
    checks++;
    if (codec_lrclk !== 1'b1) begin errors++; $display("FAIL reach_slot1: got lrclk=%b want 1", codec_lrclk); end
    repeat (20) @(negedge clk);
    rst = 1'b1;
    mclk_rate = 3'd0;
    @(negedge clk);
    checks++;
    if ({codec_rstn, codec_mclk, codec_sclk, codec_lrclk, codec_sdin, init_done} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_pins: got %b want 000000",
               {codec_rstn, codec_mclk, codec_sclk, codec_lrclk, codec_sdin, init_done});
    end
    checks++;
    if ({aud_din_ack, aud_dout_vld} !== 4'b0 || aud_dout !== 24'h0) begin
      errors++; $display("FAIL midreset_data: got strobes=%b dout=%h want 0000 000000",
                         {aud_din_ack, aud_dout_vld}, aud_dout);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k_done = -1;
    for (int k = 1; k <= 100 && k_done < 0; k++) begin
      @(negedge clk);
      if (init_done === 1'b1) k_done = k;
    end
    checks++;
    if (k_done != 24) begin errors++; $display("FAIL reinit_time: got %0d want 24 cycles", k_done); end
    ack_i = -1; ack_v = 2'b00; fell_at_ack = 1'b0; ps = codec_sclk;
    for (int i = 1; i <= 100 && ack_i < 0; i++) begin
      @(negedge clk);
      if (aud_din_ack !== 2'b00) begin
        ack_i = i; ack_v = aud_din_ack; fell_at_ack = ps && !codec_sclk;
      end
      ps = codec_sclk;
    end
    checks++;
    if (ack_i != 16 || ack_v !== 2'b01 || !fell_at_ack || codec_lrclk !== 1'b0) begin
      errors++; $display("FAIL reinit_first_ack: got t=%0d ack=%b fall=%b lr=%b want t=16 ack=01 fall=1 lr=0",
                         ack_i, ack_v, fell_at_ack, codec_lrclk);
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_first_frame;
    test_tx;
    test_rates;
    test_loopback;
    test_rate_change;
    test_reset_midslot;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
